// File: rtl/spi_arb_pkg.sv
// ============================================================================
// Module  : spi_arb_pkg
// Brief   : Shared state encoding and constants for the SPI slave-port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY0 = 3'd1,
    BUSY1 = 3'd2,
    HOLD0 = 3'd3,
    HOLD1 = 3'd4
  } arb_state_e;

  // Read data returned to a requester whose transfer was forcibly completed
  localparam logic [31:0] C_TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage : spi_arb_pkg

`default_nettype wire

// File: rtl/spi_arb_timer.sv
// ============================================================================
// Module  : spi_arb_timer
// Brief   : Saturating strobe-age counter; o_expire flags the final permitted
//           unacknowledged cycle. TIMEOUT = 0 removes the counter entirely.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  generate
    if (TIMEOUT > 0) begin : g_timer_on
      localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
      localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT - 1);

      logic [CW-1:0] r_count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (i_clear) begin
          r_count <= '0;
        end else if (i_enable && (r_count != C_LIMIT)) begin
          r_count <= r_count + 1'b1;
        end
      end

      // Count starts at 0 on the first busy cycle, so TIMEOUT-1 is the Nth cycle
      assign o_expire = (r_count == C_LIMIT);
    end else begin : g_timer_off
      logic w_unused_in;
      assign w_unused_in = clk ^ rst ^ i_clear ^ i_enable;
      assign o_expire    = 1'b0;
    end
  endgenerate

endmodule : spi_arb_timer

`default_nettype wire

// File: rtl/spi_arbiter.sv
// ============================================================================
// Module  : spi_arbiter
// Brief   : Two-requester round-robin arbiter for a single SPI slave port, with
//           optional bus hold (macro SPI_ARB_LOCK_EN) and strobe timeout.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [3:2]  m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m0_lock_i,

  input  logic [3:2]  m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  input  logic        m1_lock_i,

  output logic [3:2]  s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  arb_state_e r_state;
  arb_state_e w_next;
  logic       r_last;

  logic w_lock0;
  logic w_lock1;
  logic w_busy;
  logic w_stb;
  logic w_limit;
  logic w_done;
  logic w_timeout;

`ifdef SPI_ARB_LOCK_EN
  assign w_lock0 = m0_lock_i;
  assign w_lock1 = m1_lock_i;
`else
  logic w_unused_lock;
  assign w_lock0       = 1'b0;
  assign w_lock1       = 1'b0;
  assign w_unused_lock = m0_lock_i ^ m1_lock_i;
`endif

  assign w_busy    = (r_state == BUSY0) || (r_state == BUSY1);
  assign w_stb     = (r_state == BUSY1) ? m1_stb_i : m0_stb_i;
  assign w_done    = w_busy && w_stb && s_ack_i;
  // A slave ack in the limit cycle wins over the forced completion
  assign w_timeout = w_busy && w_stb && w_limit && !s_ack_i;

  spi_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .i_clear  (!w_busy),
    .i_enable (w_busy && w_stb && !s_ack_i),
    .o_expire (w_limit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if ((w_next == BUSY0) && (r_state != BUSY0)) begin
        r_last <= 1'b0;
      end else if ((w_next == BUSY1) && (r_state != BUSY1)) begin
        r_last <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    s_adr_o   = '0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_dat_o   = '0;
    m0_ack_o  = 1'b0;
    m0_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_dat_o  = '0;
    gnt_o     = 2'b00;
    timeout_o = w_timeout;

    case (r_state)
      IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
          w_next = r_last ? BUSY0 : BUSY1;
        end else if (m0_stb_i) begin
          w_next = BUSY0;
        end else if (m1_stb_i) begin
          w_next = BUSY1;
        end
      end

      BUSY0: begin
        gnt_o    = 2'b01;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_dat_o  = m0_dat_i;
        s_stb_o  = m0_stb_i && !w_limit;
        m0_ack_o = w_done || w_timeout;
        m0_dat_o = w_timeout ? C_TIMEOUT_DATA : s_dat_i;
        if (!m0_stb_i) begin
          w_next = IDLE;
        end else if (s_ack_i) begin
          w_next = w_lock0 ? HOLD0 : IDLE;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end

      BUSY1: begin
        gnt_o    = 2'b10;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_dat_o  = m1_dat_i;
        s_stb_o  = m1_stb_i && !w_limit;
        m1_ack_o = w_done || w_timeout;
        m1_dat_o = w_timeout ? C_TIMEOUT_DATA : s_dat_i;
        if (!m1_stb_i) begin
          w_next = IDLE;
        end else if (s_ack_i) begin
          w_next = w_lock1 ? HOLD1 : IDLE;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end

      HOLD0: begin
        gnt_o = 2'b01;
        if (m0_stb_i) begin
          w_next = BUSY0;
        end else if (!w_lock0) begin
          w_next = IDLE;
        end
      end

      HOLD1: begin
        gnt_o = 2'b10;
        if (m1_stb_i) begin
          w_next = BUSY1;
        end else if (!w_lock1) begin
          w_next = IDLE;
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule : spi_arbiter

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
// ============================================================================
// Module  : tb_spi_arbiter
// Brief   : Directed self-checking bench for spi_arbiter (TIMEOUT = 4); lock
//           expectations follow SPI_ARB_LOCK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_arbiter;

`ifdef SPI_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:2]  m0_adr, m1_adr, s_adr;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_stb, m1_stb, m0_we, m1_we, m0_lock, m1_lock;
  logic [31:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack;
  logic        s_stb, s_we, s_ack;
  logic [31:0] s_wdat, s_rdat;
  logic [1:0]  gnt;
  logic        tmo;

  int errors = 0;
  int checks = 0;

  spi_arbiter #(.TIMEOUT(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0_adr_i  (m0_adr),
    .m0_sel_i  (m0_sel),
    .m0_stb_i  (m0_stb),
    .m0_we_i   (m0_we),
    .m0_dat_i  (m0_wdat),
    .m0_dat_o  (m0_rdat),
    .m0_ack_o  (m0_ack),
    .m0_lock_i (m0_lock),
    .m1_adr_i  (m1_adr),
    .m1_sel_i  (m1_sel),
    .m1_stb_i  (m1_stb),
    .m1_we_i   (m1_we),
    .m1_dat_i  (m1_wdat),
    .m1_dat_o  (m1_rdat),
    .m1_ack_o  (m1_ack),
    .m1_lock_i (m1_lock),
    .s_adr_o   (s_adr),
    .s_sel_o   (s_sel),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_dat_o   (s_wdat),
    .s_dat_i   (s_rdat),
    .s_ack_i   (s_ack),
    .gnt_o     (gnt),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_adr = '0; m0_sel = '0; m0_stb = 0; m0_we = 0; m0_wdat = '0; m0_lock = 0;
    m1_adr = '0; m1_sel = '0; m1_stb = 0; m1_we = 0; m1_wdat = '0; m1_lock = 0;
    s_ack = 0; s_rdat = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_stb", 32'(s_stb), 32'h0);
    chk("rst_tmo", 32'(tmo), 32'h0);
    chk("rst_m0ack", 32'(m0_ack), 32'h0);
    chk("rst_sdat", s_wdat, 32'h0);

    // Single write from m0, slave acks on third busy cycle
    @(negedge clk);
    rst = 0; m0_adr = 2'b01; m0_sel = 4'hF; m0_we = 1; m0_wdat = 32'hA5; m0_stb = 1;
    #1; chk("t1_idle_stb", 32'(s_stb), 32'h0);
    @(negedge clk); #1;
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_stb", 32'(s_stb), 32'h1);
    chk("t1_sdat", s_wdat, 32'hA5);
    chk("t1_sadr", 32'(s_adr), 32'h1);
    chk("t1_swe", 32'(s_we), 32'h1);
    chk("t1_noack1", 32'(m0_ack), 32'h0);
    @(negedge clk); #1;
    chk("t1_noack2", 32'(m0_ack), 32'h0);
    @(negedge clk); s_ack = 1; #1;
    chk("t1_m0ack", 32'(m0_ack), 32'h1);
    chk("t1_m1ack", 32'(m1_ack), 32'h0);
    chk("t1_gnt3", 32'(gnt), 32'h1);
    @(negedge clk); s_ack = 0; m0_stb = 0; m0_we = 0; #1;
    chk("t1_idle_gnt", 32'(gnt), 32'h0);
    chk("t1_idle_ack", 32'(m0_ack), 32'h0);

    // Round robin from reset: m0, m1, m0
    @(negedge clk); rst = 1; #1;
    @(negedge clk);
    rst = 0; m0_stb = 1; m0_adr = 2'b00;
    m1_stb = 1; m1_adr = 2'b10; m1_we = 1; m1_wdat = 32'h11; m1_sel = 4'h3;
    @(negedge clk); #1;
    chk("t2_gnt_a", 32'(gnt), 32'h1);
    chk("t2_sadr_a", 32'(s_adr), 32'h0);
    @(negedge clk); s_ack = 1; s_rdat = 32'hDEAD_0000; #1;
    chk("t2_m0ack", 32'(m0_ack), 32'h1);
    chk("t2_m0dat", m0_rdat, 32'hDEAD_0000);
    chk("t2_m1ack_a", 32'(m1_ack), 32'h0);
    chk("t2_m1dat_a", m1_rdat, 32'h0);
    @(negedge clk); s_ack = 0; #1;
    chk("t2_idle_a", 32'(gnt), 32'h0);
    @(negedge clk); #1;
    chk("t2_gnt_b", 32'(gnt), 32'h2);
    chk("t2_sdat_b", s_wdat, 32'h11);
    chk("t2_ssel_b", 32'(s_sel), 32'h3);
    chk("t2_sadr_b", 32'(s_adr), 32'h2);
    @(negedge clk); s_ack = 1; #1;
    chk("t2_m1ack", 32'(m1_ack), 32'h1);
    chk("t2_m1dat", m1_rdat, 32'hDEAD_0000);
    chk("t2_m0ack_b", 32'(m0_ack), 32'h0);
    chk("t2_m0dat_b", m0_rdat, 32'h0);
    @(negedge clk); s_ack = 0; #1;
    chk("t2_idle_b", 32'(gnt), 32'h0);
    @(negedge clk); #1;
    chk("t2_gnt_c", 32'(gnt), 32'h1);
    @(negedge clk); s_ack = 1; #1;
    chk("t2_m0ack_c", 32'(m0_ack), 32'h1);
    @(negedge clk); s_ack = 0; m0_stb = 0; m1_stb = 0; m1_we = 0; #1;
    chk("t2_end_gnt", 32'(gnt), 32'h0);

    // Bus hold by m1 while m0 waits (round-robin pointer now at m0)
    @(negedge clk); m1_stb = 1; m1_lock = 1;
    @(negedge clk); s_ack = 1; m0_stb = 1; #1;
    chk("t3_gnt1", 32'(gnt), 32'h2);
    chk("t3_m1ack1", 32'(m1_ack), 32'h1);
    @(negedge clk); s_ack = 0; #1;
    chk("t3_gap1_gnt", 32'(gnt), LOCK ? 32'h2 : 32'h0);
    chk("t3_gap1_stb", 32'(s_stb), 32'h0);
    chk("t3_gap1_m0ack", 32'(m0_ack), 32'h0);
    @(negedge clk); s_ack = 1; #1;
    chk("t3_gnt2", 32'(gnt), LOCK ? 32'h2 : 32'h1);
    chk("t3_m0ack2", 32'(m0_ack), LOCK ? 32'h0 : 32'h1);
    chk("t3_m1ack2", 32'(m1_ack), LOCK ? 32'h1 : 32'h0);
    @(negedge clk); s_ack = 0; #1;
    chk("t3_gap2_gnt", 32'(gnt), LOCK ? 32'h2 : 32'h0);
    @(negedge clk); s_ack = 1; m1_lock = 0; #1;
    chk("t3_gnt3", 32'(gnt), 32'h2);
    chk("t3_m1ack3", 32'(m1_ack), 32'h1);
    @(negedge clk); s_ack = 0; m1_stb = 0; #1;
    chk("t3_release_gnt", 32'(gnt), 32'h0);
    @(negedge clk); #1;
    chk("t3_m0_gnt", 32'(gnt), 32'h1);
    @(negedge clk); s_ack = 1; #1;
    chk("t3_m0_ack", 32'(m0_ack), 32'h1);
    @(negedge clk); s_ack = 0; m0_stb = 0; #1;

    // Timeout: slave never acks an m0 read
    @(negedge clk); m0_stb = 1; m0_we = 0; m0_adr = 2'b11;
    @(negedge clk); #1;
    chk("t4_c1_stb", 32'(s_stb), 32'h1);
    chk("t4_c1_tmo", 32'(tmo), 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t4_c3_stb", 32'(s_stb), 32'h1);
    chk("t4_c3_ack", 32'(m0_ack), 32'h0);
    @(negedge clk); #1;
    chk("t4_c4_ack", 32'(m0_ack), 32'h1);
    chk("t4_c4_dat", m0_rdat, 32'hFFFF_FFFF);
    chk("t4_c4_tmo", 32'(tmo), 32'h1);
    chk("t4_c4_stb", 32'(s_stb), 32'h0);
    @(negedge clk); m0_stb = 0; #1;
    chk("t4_after_tmo", 32'(tmo), 32'h0);
    chk("t4_after_gnt", 32'(gnt), 32'h0);

    // Slave ack in the timeout cycle is a normal completion
    @(negedge clk); m0_stb = 1;
    repeat (4) @(negedge clk);
    s_ack = 1; s_rdat = 32'h1234_5678; #1;
    chk("t4b_ack", 32'(m0_ack), 32'h1);
    chk("t4b_dat", m0_rdat, 32'h1234_5678);
    chk("t4b_tmo", 32'(tmo), 32'h0);
    @(negedge clk); s_ack = 0; m0_stb = 0; #1;
    chk("t4b_idle", 32'(gnt), 32'h0);

    // Reset during BUSY1
    @(negedge clk); m1_stb = 1;
    @(negedge clk); #1;
    chk("t5_busy_stb", 32'(s_stb), 32'h1);
    chk("t5_busy_gnt", 32'(gnt), 32'h2);
    #2; rst = 1; s_ack = 1; #1;
    chk("t5_rst_stb", 32'(s_stb), 32'h0);
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_ack", 32'(m1_ack), 32'h0);
    @(negedge clk); rst = 0; m1_stb = 0; #1;
    chk("t5_rel_ack", 32'(m1_ack), 32'h0);
    @(negedge clk); #1;
    chk("t5_rel_ack2", 32'(m1_ack), 32'h0);
    chk("t5_rel_gnt", 32'(gnt), 32'h0);

    // m0 aborts before ack; late slave ack ignored
    @(negedge clk); s_ack = 0; m0_stb = 1;
    @(negedge clk); #1;
    chk("t6_gnt", 32'(gnt), 32'h1);
    @(negedge clk); m0_stb = 0; #1;
    chk("t6_abort_stb", 32'(s_stb), 32'h0);
    chk("t6_abort_ack", 32'(m0_ack), 32'h0);
    @(negedge clk); s_ack = 1; s_rdat = 32'hCAFE; #1;
    chk("t6_late_gnt", 32'(gnt), 32'h0);
    chk("t6_late_ack0", 32'(m0_ack), 32'h0);
    chk("t6_late_ack1", 32'(m1_ack), 32'h0);
    chk("t6_late_dat", m0_rdat, 32'h0);
    @(negedge clk); s_ack = 0; #1;
    chk("t6_end_gnt", 32'(gnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_spi_arbiter

`default_nettype wire
